// File: rtl/spm_mmio_pkg.sv
// Shared constants for the SPM memory-mapped responder: register offsets
// within the 4-word window and bit positions inside the STATUS register.
// Latency: n/a (constants only). Backpressure: n/a.
package spm_mmio_pkg;

  // Register offsets (address - BASE_ADDR)
  localparam logic [1:0] TXDATA_OFS = 2'd0;
  localparam logic [1:0] STATUS_OFS = 2'd1;
  localparam logic [1:0] RXDATA_OFS = 2'd2;
  localparam logic [1:0] TIMER_OFS  = 2'd3;

  // STATUS bit indices
  localparam int TXF  = 0;  // TX FIFO full
  localparam int TXE  = 1;  // TX FIFO empty
  localparam int RXF  = 2;  // RX holding register full
  localparam int TEXP = 3;  // timer expired (sticky, W1C)
  localparam int OVF  = 4;  // TX push dropped (sticky, W1C)

endpackage

// File: rtl/spm_tx_fifo.sv
// Synchronous FIFO buffering processor TX writes toward the output stream.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: push while full is dropped (drop=1) unless a pop happens the same cycle.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   push, push_dat  enqueue request and data
//   pop             dequeue request (ignored when empty)
//   head_dat        oldest entry, 0 while empty
//   full, empty     occupancy flags
//   drop            push rejected this cycle (combinational)
module spm_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic pop_ok;
  logic push_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // When full, a simultaneous pop frees the slot being written; wr_ptr equals
  // rd_ptr in that case, and the old head is consumed on the same edge.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;

  // Gate the head so the stream sees 0 rather than stale data when empty.
  assign head_dat = empty ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of 2, so pointer arithmetic wraps naturally.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head_dat is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/spm_mmio_responder.sv
// MMIO responder beside the SPM memory: TX FIFO, STATUS, RX holding register, countdown timer.
// Latency: reads are combinational (zero-wait); writes take effect on the next clk edge; irq is registered.
// Backpressure: TX push dropped when full (sets ovf); rx_ready low while the RX holding register is full.
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   address, data_in, write  processor memory-bus request
//   hit, data_out            window decode and read data (0 outside the window)
//   tx_data/tx_valid/tx_ready  output stream from the TX FIFO
//   rx_data/rx_valid/rx_ready  input stream into the RX holding register
//   irq                      registered timer_exp | rx_full
module spm_mmio_responder
  import spm_mmio_pkg::*;
#(
  parameter int                   WORD_SIZE = 8,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR = 8'hF8,
  parameter int                   TX_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data_in,
  input  logic                 write,
  output logic                 hit,
  output logic [WORD_SIZE-1:0] data_out,
  output logic [WORD_SIZE-1:0] tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [WORD_SIZE-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic                 irq
);

  localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

  logic [1:0] ofs;
  logic       wr_en;
  logic       tx_push, sts_wr, rx_pop, timer_ld;
  logic       tx_full, tx_empty, tx_drop;
  logic       rx_cap;
  logic       texp_set;

  logic                 rx_full_q,   rx_full_d;
  logic [WORD_SIZE-1:0] rxbuf_q,     rxbuf_d;
  logic [WORD_SIZE-1:0] timer_q,     timer_d;
  logic                 timer_exp_q, timer_exp_d;
  logic                 ovf_q,       ovf_d;
  logic                 irq_q,       irq_d;
  logic [WORD_SIZE-1:0] status;

  // BASE_ADDR is 4-aligned, so the window is matched on the upper bits alone.
  assign hit   = (address[WORD_SIZE-1:2] == BASE_ADDR[WORD_SIZE-1:2]);
  assign ofs   = address[1:0];
  assign wr_en = write & hit;

  assign tx_push  = wr_en & (ofs == TXDATA_OFS);
  assign sts_wr   = wr_en & (ofs == STATUS_OFS);
  assign rx_pop   = wr_en & (ofs == RXDATA_OFS);
  assign timer_ld = wr_en & (ofs == TIMER_OFS);

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full_q;
  assign rx_cap   = rx_valid & rx_ready;
  assign irq      = irq_q;

  spm_tx_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_push),
    .push_dat (data_in),
    .pop      (tx_ready),
    .head_dat (tx_data),
    .full     (tx_full),
    .empty    (tx_empty),
    .drop     (tx_drop)
  );

  // A load pre-empts the decrement, so a load while at 1 never expires.
  assign texp_set = ~timer_ld & (timer_q == ONE);

  always_comb begin
    rx_full_d   = rx_full_q;
    rxbuf_d     = rxbuf_q;
    timer_d     = timer_q;
    timer_exp_d = timer_exp_q;
    ovf_d       = ovf_q;

    // Capture and pop are exclusive: capture needs rx_full=0, and a pop while
    // empty is a no-op.
    if (rx_cap) begin
      rxbuf_d   = rx_data;
      rx_full_d = 1'b1;
    end else if (rx_pop) begin
      rx_full_d = 1'b0;
    end

    if (timer_ld)             timer_d = data_in;
    else if (timer_q != '0)   timer_d = timer_q - ONE;

    // Sticky bits: set beats W1C clear.
    if (texp_set)                  timer_exp_d = 1'b1;
    else if (sts_wr && data_in[TEXP]) timer_exp_d = 1'b0;

    if (tx_drop)                   ovf_d = 1'b1;
    else if (sts_wr && data_in[OVF])  ovf_d = 1'b0;

    irq_d = timer_exp_d | rx_full_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_full_q   <= 1'b0;
      rxbuf_q     <= '0;
      timer_q     <= '0;
      timer_exp_q <= 1'b0;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      rx_full_q   <= rx_full_d;
      rxbuf_q     <= rxbuf_d;
      timer_q     <= timer_d;
      timer_exp_q <= timer_exp_d;
      ovf_q       <= ovf_d;
      irq_q       <= irq_d;
    end
  end

  always_comb begin
    status       = '0;
    status[TXF]  = tx_full;
    status[TXE]  = tx_empty;
    status[RXF]  = rx_full_q;
    status[TEXP] = timer_exp_q;
    status[OVF]  = ovf_q;
  end

  always_comb begin
    data_out = '0;
    if (hit) begin
      case (ofs)
        STATUS_OFS: data_out = status;
        RXDATA_OFS: data_out = rxbuf_q;
        TIMER_OFS:  data_out = timer_q;
        default:    data_out = '0;  // TXDATA is write-only
      endcase
    end
  end

endmodule
